// File: rtl/muldiv_unit.sv
// Iterative HI/LO multiply/divide unit: shift-add multiply and restoring divide
// on operand magnitudes, one bit per cycle, with sign fix-up in the final state.
module muldiv_unit #(
    parameter int unsigned data_width = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [data_width-1:0] rs_data,
    input  logic [data_width-1:0] rt_data,
    input  logic [1:0]            hilo_we,
    input  logic [data_width-1:0] hilo_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [data_width-1:0] hi,
    output logic [data_width-1:0] lo
);
    localparam int unsigned W  = data_width;
    localparam int unsigned CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t        state, next_state;
    logic [CW-1:0] count;
    logic [1:0]    op_q;
    logic [W-1:0]  rs_q, rt_q;
    logic [2*W-1:0] acc, acc_step;
    logic [W-1:0]  mag_rs, mag_rt, mag_rs_in, mag_rt_in;
    logic [W:0]    sum, shifted, trial;
    logic [W-1:0]  res_hi, res_lo;
    logic          is_signed, is_div, sign_diff;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic sgn);
        return (sgn && v[W-1]) ? -v : v;
    endfunction

    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];
    assign sign_diff = is_signed & (rs_q[W-1] ^ rt_q[W-1]);
    assign mag_rs    = magnitude(rs_q, is_signed);
    assign mag_rt    = magnitude(rt_q, is_signed);
    assign mag_rs_in = magnitude(rs_data, ~op[0]);
    assign mag_rt_in = magnitude(rt_data, ~op[0]);
    assign busy      = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (count == LAST) next_state = FIN;
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // acc holds {partial product} for multiply, {remainder, dividend/quotient} for divide
    always_comb begin
        sum      = '0;
        shifted  = '0;
        trial    = '0;
        acc_step = acc;
        if (is_div) begin
            shifted = {acc[2*W-1:W], acc[W-1]};
            trial   = shifted - {1'b0, mag_rt};
            if (!trial[W]) acc_step = {trial[W-1:0], acc[W-2:0], 1'b1};
            else           acc_step = {shifted[W-1:0], acc[W-2:0], 1'b0};
        end else begin
            sum      = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, mag_rs} : '0);
            acc_step = {sum, acc[W-1:1]};
        end
    end

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        if (!is_div) begin
            {res_hi, res_lo} = sign_diff ? -acc : acc;
        end else if (rt_q == '0) begin
            res_hi = rs_q;
            res_lo = '1;
        end else begin
            res_lo = sign_diff ? -acc[W-1:0] : acc[W-1:0];
            res_hi = (is_signed && rs_q[W-1]) ? -acc[2*W-1:W] : acc[2*W-1:W];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            op_q  <= '0;
            rs_q  <= '0;
            rt_q  <= '0;
            acc   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= op;
                        rs_q  <= rs_data;
                        rt_q  <= rt_data;
                        count <= '0;
                        acc   <= op[1] ? {{W{1'b0}}, mag_rs_in} : {{W{1'b0}}, mag_rt_in};
                    end else begin
                        if (hilo_we[1]) hi <= hilo_wdata;
                        if (hilo_we[0]) lo <= hilo_wdata;
                    end
                end
                RUN: begin
                    acc   <= acc_step;
                    count <= count + 1'b1;
                end
                FIN: begin
                    hi   <= res_hi;
                    lo   <= res_lo;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus random
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;
    logic        clock = 1'b0;
    logic        reset, start;
    logic [1:0]  op, hilo_we;
    logic [31:0] rs_data, rt_data, hilo_wdata;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    always #5 clock = ~clock;

    muldiv_unit #(.data_width(32)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // {hi, lo} from plain integer arithmetic
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int ia, ib;
        longint sa, sb, q, r;
        logic [63:0] p;
        ia = a; ib = b; sa = ia; sb = ib;
        case (o)
            2'b00: begin q = sa * sb; p = q; end
            2'b01: p = {32'b0, a} * {32'b0, b};
            2'b10: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            check({tag, "_busy"}, {31'b0, busy}, 32'h0);
            check({tag, "_done"}, {31'b0, done}, 32'h0);
            check({tag, "_hi"}, hi, hi_m);
            check({tag, "_lo"}, lo, lo_m);
        end
    endtask

    // Called in the low phase of the start cycle; returns in the low phase of the done cycle.
    // mode 1: hilo_we asserted with start; mode 2: start + hilo write injected in busy cycle 10.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mode, input string tag);
        logic [63:0] r;
        r = ref_result(o, a, b);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        if (mode == 1) begin hilo_we = 2'b11; hilo_wdata = 32'h5555_AAAA; end
        for (int cyc = 1; cyc <= 34; cyc++) begin
            @(negedge clock);
            start = 1'b0; hilo_we = 2'b00;
            rs_data = $urandom; rt_data = $urandom; op = 2'($urandom);
            if (cyc <= 33) begin
                check({tag, "_busy"}, {31'b0, busy}, 32'h1);
                check({tag, "_done"}, {31'b0, done}, 32'h0);
                check({tag, "_hi_hold"}, hi, hi_m);
                check({tag, "_lo_hold"}, lo, lo_m);
            end else begin
                hi_m = r[63:32];
                lo_m = r[31:0];
                check({tag, "_busy_end"}, {31'b0, busy}, 32'h0);
                check({tag, "_done_pulse"}, {31'b0, done}, 32'h1);
                check({tag, "_hi"}, hi, hi_m);
                check({tag, "_lo"}, lo, lo_m);
            end
            if (mode == 2 && cyc == 10) begin
                start = 1'b1; hilo_we = 2'b11; hilo_wdata = 32'h0000_1234;
            end
        end
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        reset = 1'b1; start = 1'b0; op = 2'b00; hilo_we = 2'b00;
        rs_data = '0; rt_data = '0; hilo_wdata = '0;
        @(negedge clock);
        @(negedge clock);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);

        // reset wins over start and hilo_we
        start = 1'b1; hilo_we = 2'b11; hilo_wdata = 32'hFFFF_0000;
        @(negedge clock);
        check("rst_prio_busy", {31'b0, busy}, 32'h0);
        check("rst_prio_hi", hi, 32'h0);
        check("rst_prio_lo", lo, 32'h0);
        reset = 1'b0; start = 1'b0; hilo_we = 2'b00;
        idle(1, "post_reset");

        hilo_we = 2'b01; hilo_wdata = 32'h1111_2222;
        @(negedge clock);
        lo_m = 32'h1111_2222;
        check("mtlo_lo", lo, lo_m);
        check("mtlo_hi", hi, hi_m);
        hilo_we = 2'b00;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "multu_max");
        check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max_lo_const", lo, 32'h0000_0001);
        idle(1, "gap1");
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 0, "mult_neg");
        check("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
        check("mult_neg_lo_const", lo, 32'hFFFF_FFF1);
        // back-to-back: next start in the done cycle
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, "div_neg");
        check("div_neg_hi_const", hi, 32'hFFFF_FFFF);
        check("div_neg_lo_const", lo, 32'hFFFF_FFFD);
        run_op(2'b11, 32'h0000_0064, 32'h0, 0, "divu_zero");
        check("divu_zero_hi_const", hi, 32'h0000_0064);
        check("divu_zero_lo_const", lo, 32'hFFFF_FFFF);
        idle(1, "gap2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
        check("div_ovf_hi_const", hi, 32'h0000_0000);
        check("div_ovf_lo_const", lo, 32'h8000_0000);
        idle(1, "gap3");
        run_op(2'b10, 32'hFFFF_FF9C, 32'h0, 0, "div_zero");
        idle(1, "gap4");

        run_op(2'b11, 32'd1000, 32'd7, 2, "intrude");
        idle(1, "gap5");
        hilo_we = 2'b10; hilo_wdata = 32'h0000_ABCD;
        @(negedge clock);
        hi_m = 32'h0000_ABCD;
        check("mthi_hi", hi, hi_m);
        check("mthi_lo", lo, lo_m);
        hilo_we = 2'b00;
        idle(1, "gap6");
        run_op(2'b00, 32'h0000_0007, 32'hFFFF_FFFE, 1, "start_vs_we");
        idle(1, "gap7");

        // reset in busy cycle 10 of a MULTU
        hilo_we = 2'b11; hilo_wdata = 32'hDEAD_BEEF;
        @(negedge clock);
        hi_m = 32'hDEAD_BEEF; lo_m = 32'hDEAD_BEEF;
        hilo_we = 2'b00;
        start = 1'b1; op = 2'b01; rs_data = $urandom; rt_data = $urandom;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            check("abort_busy", {31'b0, busy}, 32'h1);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        hi_m = '0; lo_m = '0;
        check("abort_busy_low", {31'b0, busy}, 32'h0);
        check("abort_done_low", {31'b0, done}, 32'h0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        idle(40, "abort_quiet");

        for (int n = 0; n < 60; n++) begin
            ro = 2'($urandom);
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, 0, $sformatf("rnd%0d_op%0d", n, ro));
            if ($urandom_range(0, 2) != 0) idle(1, "rnd_gap");
        end
        idle(2, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
